// File: rtl/vme_master_seq_pkg.sv
// ============================================================================
// Module : vme_master_seq_pkg
// Brief  : Shared FSM encoding, command-word bit positions and VME defaults.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package vme_master_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDR     = 3'd1,
        ST_STROBE   = 3'd2,
        ST_WAIT_ACK = 3'd3,
        ST_RELEASE  = 3'd4,
        ST_DONE     = 3'd5
    } state_t;

    localparam int         RW_BIT          = 25;
    localparam int         ADDR_MSB        = 23;
    localparam logic [5:0] AM_CODE_DEFAULT = 6'h39;

    // Bits needed to hold 0..limit without wrapping.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/vme_timeout_cnt.sv
// ============================================================================
// Module : vme_timeout_cnt
// Brief  : Clear/enable saturating cycle counter with terminal-count flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vme_timeout_cnt
    import vme_master_seq_pkg::*;
#(
    parameter int LIMIT = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int             W       = cnt_width(LIMIT);
    localparam logic [W-1:0]   C_LIMIT = W'(LIMIT);
    localparam logic [W-1:0]   C_LAST  = W'(LIMIT - 1);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != C_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Counter starts at 0 after a clear, so this flags the LIMIT-th enabled cycle.
    assign o_tc = (r_cnt >= C_LAST);

endmodule

`default_nettype wire

// File: rtl/vme_master_seq.sv
// ============================================================================
// Module : vme_master_seq
// Brief  : VME A24/D16 single-transfer bus master sequencer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module vme_master_seq
    import vme_master_seq_pkg::*;
#(
    parameter int         SETUP_CYC = 2,
    parameter int         TIMEOUT   = 255,
    parameter logic [5:0] AM_CODE   = AM_CODE_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic [31:0] vme_cmd_reg,
    input  logic [31:0] vme_dat_reg_in,
    output logic        vme_cmd_rd,
    output logic        vme_dat_wr,
    output logic [31:0] vme_dat_reg_out,
    output logic        vme_err,
    output logic [22:0] vme_addr,
    output logic [5:0]  vme_am,
    output logic        vme_as_b,
    output logic        vme_write_b,
    output logic [1:0]  vme_ds_b,
    output logic [15:0] vme_d_out,
    output logic        vme_d_oe,
    input  logic [15:0] vme_d_in,
    input  logic        vme_dtack_b,
    input  logic        vme_berr_b
);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_rw;
    logic        w_rw_nxt;
    logic        r_err_flag;
    logic        w_err_nxt;
    logic [15:0] r_rdata;
    logic [15:0] w_rdata_nxt;

    logic        w_accept;
    logic        w_cnt_clr;
    logic        w_setup_en;
    logic        w_setup_tc;
    logic        w_to_en;
    logic        w_to_tc;

    logic        r_dat_wr;
    logic [31:0] r_dat_out;
    logic        r_vme_err;
    logic [22:0] r_addr;
    logic [5:0]  r_am;
    logic        r_as_b;
    logic        r_write_b;
    logic [1:0]  r_ds_b;
    logic [15:0] r_d_out;
    logic        r_d_oe;

    logic        w_unused;
    assign w_unused = ^{vme_cmd_reg[31:26], vme_cmd_reg[24], vme_cmd_reg[0],
                        vme_dat_reg_in[31:16]};

    assign w_accept   = (r_state == ST_IDLE) && start;
    // Every state change restarts both counters so each phase times from zero.
    assign w_cnt_clr  = (w_state_nxt != r_state);
    assign w_setup_en = (r_state == ST_ADDR) || (r_state == ST_STROBE);
    assign w_to_en    = (r_state == ST_WAIT_ACK) || (r_state == ST_RELEASE);

    vme_timeout_cnt #(
        .LIMIT (SETUP_CYC)
    ) u_setup_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .i_clr (w_cnt_clr),
        .i_en  (w_setup_en),
        .o_tc  (w_setup_tc)
    );

    vme_timeout_cnt #(
        .LIMIT (TIMEOUT)
    ) u_timeout_cnt (
        .clk   (clk),
        .rstn  (rstn),
        .i_clr (w_cnt_clr),
        .i_en  (w_to_en),
        .o_tc  (w_to_tc)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= ST_IDLE;
            r_rw       <= 1'b0;
            r_err_flag <= 1'b0;
            r_rdata    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rw       <= w_rw_nxt;
            r_err_flag <= w_err_nxt;
            r_rdata    <= w_rdata_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rw_nxt    = r_rw;
        w_err_nxt   = r_err_flag;
        w_rdata_nxt = r_rdata;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ADDR;
                    w_rw_nxt    = vme_cmd_reg[RW_BIT];
                    w_err_nxt   = 1'b0;
                    w_rdata_nxt = '0;
                end
            end
            ST_ADDR: begin
                if (w_setup_tc) begin
                    w_state_nxt = ST_STROBE;
                end
            end
            ST_STROBE: begin
                if (w_setup_tc) begin
                    w_state_nxt = ST_WAIT_ACK;
                end
            end
            ST_WAIT_ACK: begin
                // Bus error outranks a simultaneous DTACK; read data stays zero.
                if (!vme_berr_b) begin
                    w_state_nxt = ST_RELEASE;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = '0;
                end else if (!vme_dtack_b) begin
                    w_state_nxt = ST_RELEASE;
                    if (r_rw) begin
                        w_rdata_nxt = vme_d_in;
                    end
                end else if (w_to_tc) begin
                    w_state_nxt = ST_RELEASE;
                    w_err_nxt   = 1'b1;
                end
            end
            ST_RELEASE: begin
                if (vme_dtack_b && vme_berr_b) begin
                    w_state_nxt = ST_DONE;
                end else if (w_to_tc) begin
                    w_state_nxt = ST_DONE;
                    w_err_nxt   = 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from the next state so they switch on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_dat_wr  <= 1'b0;
            r_dat_out <= '0;
            r_vme_err <= 1'b0;
            r_addr    <= '0;
            r_am      <= '0;
            r_as_b    <= 1'b1;
            r_write_b <= 1'b1;
            r_ds_b    <= 2'b11;
            r_d_out   <= '0;
            r_d_oe    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= vme_cmd_reg[ADDR_MSB:1];
                r_am    <= AM_CODE;
                r_d_out <= vme_dat_reg_in[15:0];
            end
            r_write_b <= (w_state_nxt == ST_IDLE) ? 1'b1 : w_rw_nxt;
            r_as_b    <= !((w_state_nxt == ST_STROBE) || (w_state_nxt == ST_WAIT_ACK));
            r_ds_b    <= (w_state_nxt == ST_WAIT_ACK) ? 2'b00 : 2'b11;
            r_d_oe    <= !w_rw_nxt && ((w_state_nxt == ST_ADDR) ||
                                       (w_state_nxt == ST_STROBE) ||
                                       (w_state_nxt == ST_WAIT_ACK));
            r_dat_wr  <= (w_state_nxt == ST_DONE);
            if (w_state_nxt == ST_DONE) begin
                r_vme_err <= w_err_nxt;
                r_dat_out <= w_err_nxt ? 32'h0 : {16'h0, w_rdata_nxt};
            end
        end
    end

    assign vme_cmd_rd      = (r_state == ST_IDLE);
    assign vme_dat_wr      = r_dat_wr;
    assign vme_dat_reg_out = r_dat_out;
    assign vme_err         = r_vme_err;
    assign vme_addr        = r_addr;
    assign vme_am          = r_am;
    assign vme_as_b        = r_as_b;
    assign vme_write_b     = r_write_b;
    assign vme_ds_b        = r_ds_b;
    assign vme_d_out       = r_d_out;
    assign vme_d_oe        = r_d_oe;

endmodule

`default_nettype wire

// File: tb/tb_vme_master_seq.sv
// ============================================================================
// Module : tb_vme_master_seq
// Brief  : Directed and randomized VME master transfers against a slave model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_vme_master_seq;

    localparam int SETUP = 2;
    localparam int TMO   = 255;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic [31:0] cmd = '0;
    logic [31:0] wdat = '0;
    logic [15:0] d_in = '0;
    logic        dtack_b = 1'b1;
    logic        berr_b = 1'b1;

    logic        vme_cmd_rd;
    logic        vme_dat_wr;
    logic [31:0] vme_dat_reg_out;
    logic        vme_err;
    logic [22:0] vme_addr;
    logic [5:0]  vme_am;
    logic        vme_as_b;
    logic        vme_write_b;
    logic [1:0]  vme_ds_b;
    logic [15:0] vme_d_out;
    logic        vme_d_oe;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    vme_master_seq #(
        .SETUP_CYC (SETUP),
        .TIMEOUT   (TMO),
        .AM_CODE   (6'h39)
    ) dut (
        .clk             (clk),
        .rstn            (rstn),
        .start           (start),
        .vme_cmd_reg     (cmd),
        .vme_dat_reg_in  (wdat),
        .vme_cmd_rd      (vme_cmd_rd),
        .vme_dat_wr      (vme_dat_wr),
        .vme_dat_reg_out (vme_dat_reg_out),
        .vme_err         (vme_err),
        .vme_addr        (vme_addr),
        .vme_am          (vme_am),
        .vme_as_b        (vme_as_b),
        .vme_write_b     (vme_write_b),
        .vme_ds_b        (vme_ds_b),
        .vme_d_out       (vme_d_out),
        .vme_d_oe        (vme_d_oe),
        .vme_d_in        (d_in),
        .vme_dtack_b     (dtack_b),
        .vme_berr_b      (berr_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (vme_cmd_rd !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, {31'h0, vme_cmd_rd}, 32'h1);
    endtask

    // mode: 0 = DTACK, 1 = BERR, 2 = DTACK+BERR together, 3 = silent slave (timeout).
    // dly: extra cycles the slave waits after seeing DS low. busy_at: cycle index of a stray start (-1 = none).
    task automatic do_cmd(input string tag, input logic [31:0] c, input logic [31:0] w,
                          input logic [15:0] rd, input int dly, input int mode, input int busy_at);
        logic        exp_rd;
        logic        exp_err;
        logic [31:0] exp_out;
        logic [22:0] exp_addr;
        int          exp_lat;
        int          n0;
        int          n1;
        int          lowcnt;
        int          bad;
        int          pulses;
        bit          asserted;
        exp_rd   = c[25];
        exp_err  = (mode != 0);
        exp_addr = c[23:1];
        exp_out  = (exp_rd && mode == 0) ? {16'h0, rd} : 32'h0;
        // Inclusive count from the start cycle to the completion-pulse cycle.
        exp_lat  = (mode == 3) ? (2 * SETUP + 3 + TMO) : (2 * SETUP + 4 + dly);
        n1 = -1; lowcnt = 0; bad = 0; pulses = 0; asserted = 1'b0;

        wait_ready(tag);
        cmd = c; wdat = w; start = 1'b1; n0 = cyc;
        for (int i = 0; i < 2 * SETUP + TMO + 40 && pulses == 0; i++) begin
            @(negedge clk);
            start = (i == busy_at);
            if (i == busy_at) begin
                cmd  = ~c;
                wdat = ~w;
            end
            if (vme_dat_wr === 1'b1) begin
                pulses++;
                n1 = cyc;
            end else begin
                if (vme_cmd_rd !== 1'b0) bad++;
                if (vme_as_b === 1'b0) begin
                    if (vme_addr !== exp_addr) bad++;
                    if (vme_am !== 6'h39) bad++;
                    if (vme_write_b !== exp_rd) bad++;
                    if (vme_d_oe !== !exp_rd) bad++;
                    if (!exp_rd && vme_d_out !== w[15:0]) bad++;
                end
                if (vme_ds_b === 2'b00 && vme_as_b !== 1'b0) bad++;
                if (vme_ds_b === 2'b00) begin
                    lowcnt++;
                    if (lowcnt > dly && !asserted && mode != 3) begin
                        asserted = 1'b1;
                        d_in     = rd;
                        dtack_b  = !(mode == 0 || mode == 2);
                        berr_b   = !(mode == 1 || mode == 2);
                    end
                end else if (vme_ds_b === 2'b11 && asserted) begin
                    dtack_b = 1'b1;
                    berr_b  = 1'b1;
                    d_in    = 16'($urandom);
                end
            end
        end
        start = 1'b0;
        dtack_b = 1'b1;
        berr_b  = 1'b1;

        chk({tag, "_pulse"}, pulses, 1);
        chk({tag, "_latency"}, n1 - n0 + 1, exp_lat);
        chk({tag, "_err"}, {31'h0, vme_err}, {31'h0, exp_err});
        chk({tag, "_rdata"}, vme_dat_reg_out, exp_out);
        chk({tag, "_bus"}, bad, 0);
        @(negedge clk);
        chk({tag, "_single"}, {31'h0, vme_dat_wr}, 32'h0);
        chk({tag, "_idle"}, {31'h0, vme_cmd_rd}, 32'h1);
        chk({tag, "_hold"}, vme_dat_reg_out, exp_out);
        chk({tag, "_released"}, {28'h0, vme_as_b, vme_ds_b, vme_d_oe}, 32'hE);
    endtask

    initial begin
        logic [31:0] rc;
        logic [31:0] rw;
        logic [15:0] rr;
        int          rmode;
        int          rbusy;
        int          n;
        int          pulses;

        rstn = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_rd",  {31'h0, vme_cmd_rd}, 32'h1);
        chk("rst_as_b",    {31'h0, vme_as_b}, 32'h1);
        chk("rst_ds_b",    {30'h0, vme_ds_b}, 32'h3);
        chk("rst_write_b", {31'h0, vme_write_b}, 32'h1);
        chk("rst_d_oe",    {31'h0, vme_d_oe}, 32'h0);
        chk("rst_dat_wr",  {31'h0, vme_dat_wr}, 32'h0);
        chk("rst_err",     {31'h0, vme_err}, 32'h0);
        chk("rst_dat_out", vme_dat_reg_out, 32'h0);
        chk("rst_addr",    {9'h0, vme_addr}, 32'h0);
        chk("rst_am",      {26'h0, vme_am}, 32'h0);
        chk("rst_d_out",   {16'h0, vme_d_out}, 32'h0);
        rstn = 1'b1;
        @(negedge clk);

        do_cmd("wr",    32'h00004000, 32'h0000BEEF, 16'h0000, 3, 0, -1);
        do_cmd("rd",    32'h02F80010, 32'h00000000, 16'h1234, 0, 0, -1);
        do_cmd("tmo",   32'h02000100, 32'h00000000, 16'hAAAA, 0, 3, -1);
        do_cmd("both",  32'h02123456, 32'h00000000, 16'h5555, 1, 2, -1);
        do_cmd("berrw", 32'h00ABCDE0, 32'h0000C0DE, 16'h0000, 0, 1, -1);
        do_cmd("busy1", 32'h00000020, 32'h00001111, 16'h0000, 2, 0, 2);
        do_cmd("busy2", 32'h02000040, 32'h00000000, 16'h7777, 0, 0, 5);

        for (int k = 0; k < 10; k++) begin
            rc    = $urandom;
            rw    = $urandom;
            rr    = 16'($urandom);
            rmode = $urandom_range(0, 5);
            rmode = (rmode < 4) ? 0 : rmode - 3;
            rbusy = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 8)) : -1;
            do_cmd($sformatf("rnd%0d", k), rc, rw, rr, int'($urandom_range(0, 5)), rmode, rbusy);
        end

        // Reset while the master is stuck waiting for an acknowledge.
        wait_ready("rstw");
        cmd = 32'h02000200; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (vme_ds_b !== 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("rstw_reached_wait", {30'h0, vme_ds_b}, 32'h0);
        repeat (4) @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        chk("rstw_as_b",   {31'h0, vme_as_b}, 32'h1);
        chk("rstw_ds_b",   {30'h0, vme_ds_b}, 32'h3);
        chk("rstw_cmd_rd", {31'h0, vme_cmd_rd}, 32'h1);
        chk("rstw_dat_wr", {31'h0, vme_dat_wr}, 32'h0);
        chk("rstw_d_oe",   {31'h0, vme_d_oe}, 32'h0);
        rstn = 1'b1;
        pulses = 0;
        repeat (TMO + 20) begin
            @(negedge clk);
            if (vme_dat_wr === 1'b1) pulses++;
        end
        chk("rstw_no_pulse", pulses, 0);

        do_cmd("post", 32'h02000300, 32'h00000000, 16'h4321, 0, 0, -1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
